// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and sweep-length helper for the ALU sweep controller.
package alu_pkg;

  localparam int ALU_W     = 4;
  localparam int ALU_SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_OUT   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int step_count(input int sel_w);
    return 2 ** (sel_w + 1);
  endfunction

endpackage

// File: rtl/alu_hold_timer.sv
// Settle timer: down-counter reloaded while load is high, expire marks the last enabled cycle.
module alu_hold_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // terminal count reached while enabled ends the hold window
  assign expire = enable && !load && (cnt == '0);

endmodule

// File: rtl/alu_sweep_ctrl.sv
// Sweeps all {select, carry-in} combinations of the ALU for one latched operand pair
// and streams the captured results. Optional cout statistics via ALU_SWEEP_STATS_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for i_start, ALU inputs hold last driven values
// ST_DRIVE | current {sel,cin} applied, settle timer running
// ST_OUT   | captured result presented, waiting for i_res_ready
// ST_DONE  | one-cycle o_done pulse, then back to idle
module alu_sweep_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH       = ALU_W,
  parameter int SEL_W       = ALU_SEL_W,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [SEL_W-1:0] o_alu_sel,
  output logic             o_alu_cin,
  input  logic [WIDTH-1:0] i_alu_g,
  input  logic             i_alu_cout,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_g,
  output logic             o_res_cout,
  output logic [SEL_W:0]   o_res_idx,
`ifdef ALU_SWEEP_STATS_EN
  output logic [SEL_W+1:0] o_cout_cnt,
`endif
  output logic             o_done
);

  localparam int IDX_W = SEL_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(step_count(SEL_W) - 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("alu_sweep_ctrl: HOLD_CYCLES must be >= 1");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             hold_load;
  logic             hold_expire;

  // timer is reloaded in every non-DRIVE cycle so each DRIVE visit starts fresh
  assign hold_load = (state != ST_DRIVE);

  alu_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (i_clk),
    .rst    (i_rst),
    .load   (hold_load),
    .enable (state == ST_DRIVE),
    .expire (hold_expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      o_busy      <= 1'b0;
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_alu_sel   <= '0;
      o_alu_cin   <= 1'b0;
      o_res_valid <= 1'b0;
      o_res_g     <= '0;
      o_res_cout  <= 1'b0;
      o_res_idx   <= '0;
      o_done      <= 1'b0;
`ifdef ALU_SWEEP_STATS_EN
      o_cout_cnt  <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_alu_a   <= i_a;
            o_alu_b   <= i_b;
            idx       <= '0;
            o_alu_sel <= '0;
            o_alu_cin <= 1'b0;
            o_busy    <= 1'b1;
`ifdef ALU_SWEEP_STATS_EN
            o_cout_cnt <= '0;
`endif
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (hold_expire) begin
            o_res_g     <= i_alu_g;
            o_res_cout  <= i_alu_cout;
            o_res_idx   <= idx;
            o_res_valid <= 1'b1;
            state       <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
`ifdef ALU_SWEEP_STATS_EN
            if (o_res_cout) begin
              o_cout_cnt <= o_cout_cnt + 1'b1;
            end
`endif
            if (idx == IDX_LAST) begin
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else begin
              idx                    <= idx + 1'b1;
              {o_alu_sel, o_alu_cin} <= idx + 1'b1;
              state                  <= ST_DRIVE;
            end
          end
        end
        ST_DONE: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
